// File: rtl/line_raster_pkg.sv
// Shared types and constants for the line rasteriser: FSM state encoding
// and the default coordinate width.
package line_raster_pkg;

  localparam int COORD_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/line_step.sv
// One Bresenham step: from the current pixel and error term, produce the
// next pixel and error. Purely combinational.
module line_step #(
  parameter int W = 10
) (
  input  logic [W-1:0]        x,
  input  logic [W-1:0]        y,
  input  logic signed [W+1:0] err,
  input  logic signed [W+1:0] dx,
  input  logic signed [W+1:0] dy,
  input  logic                sx_neg,
  input  logic                sy_neg,
  output logic [W-1:0]        x_next,
  output logic [W-1:0]        y_next,
  output logic signed [W+1:0] err_next
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic signed [W+2:0] e2;
  logic signed [W+2:0] dx_ext;
  logic signed [W+2:0] dy_ext;
  logic signed [W+2:0] err_acc;
  logic                step_x;
  logic                step_y;

  // One extra bit so 2*err and the double update cannot wrap.
  always_comb begin
    e2      = {err, 1'b0};
    dx_ext  = {dx[W+1], dx};
    dy_ext  = {dy[W+1], dy};
    step_x  = (e2 >= dy_ext);
    step_y  = (e2 <= dx_ext);
    err_acc = {err[W+1], err};
    if (step_x) err_acc = err_acc + dy_ext;
    if (step_y) err_acc = err_acc + dx_ext;
    err_next = err_acc[W+1:0];
    x_next   = x;
    y_next   = y;
    if (step_x) x_next = sx_neg ? (x - ONE) : (x + ONE);
    if (step_y) y_next = sy_neg ? (y - ONE) : (y + ONE);
  end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser with a ready/valid pixel output.
// Define LINE_RASTER_CLIP_EN to suppress (and skip in one cycle) pixels
// beyond XMAX/YMAX.
module line_raster
  import line_raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int XMAX    = 639,
  parameter int YMAX    = 479
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COORD_W-1:0] stax,
  input  logic [COORD_W-1:0] stay,
  input  logic [COORD_W-1:0] endx,
  input  logic [COORD_W-1:0] endy,
  input  logic               go,
  output logic               busy,
  output logic               done,
  input  logic               ready,
  output logic               wr,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  state_t state_reg, state_next;

  logic [COORD_W-1:0]        x_reg, y_reg, endx_reg, endy_reg;
  logic signed [COORD_W+1:0] err_reg, dx_reg, dy_reg;
  logic                      sx_neg_reg, sy_neg_reg;

  logic [COORD_W-1:0]        x_next, y_next;
  logic signed [COORD_W+1:0] err_next;

  logic                      load, accept, at_end, clipped;
  logic [COORD_W-1:0]        adx, ady;
  logic signed [COORD_W+1:0] dx_load, dy_load;

  assign adx     = (endx >= stax) ? (endx - stax) : (stax - endx);
  assign ady     = (endy >= stay) ? (endy - stay) : (stay - endy);
  assign dx_load = $signed({2'b00, adx});
  assign dy_load = -$signed({2'b00, ady});

`ifdef LINE_RASTER_CLIP_EN
  localparam logic [COORD_W:0] XLIM = (COORD_W+1)'(XMAX);
  localparam logic [COORD_W:0] YLIM = (COORD_W+1)'(YMAX);
  assign clipped = ({1'b0, x_reg} > XLIM) || ({1'b0, y_reg} > YLIM);
`else
  assign clipped = 1'b0;
`endif

  assign load   = go && (state_reg != RUN);
  assign accept = (state_reg == RUN) && (ready || clipped);
  assign at_end = (x_reg == endx_reg) && (y_reg == endy_reg);

  line_step #(.W(COORD_W)) u_step (
    .x        (x_reg),
    .y        (y_reg),
    .err      (err_reg),
    .dx       (dx_reg),
    .dy       (dy_reg),
    .sx_neg   (sx_neg_reg),
    .sy_neg   (sy_neg_reg),
    .x_next   (x_next),
    .y_next   (y_next),
    .err_next (err_next)
  );

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    wr         = 1'b0;
    case (state_reg)
      IDLE: if (go) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        wr   = !clipped;
        if (accept && at_end) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = go ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      err_reg    <= '0;
      dx_reg     <= '0;
      dy_reg     <= '0;
      endx_reg   <= '0;
      endy_reg   <= '0;
      sx_neg_reg <= 1'b0;
      sy_neg_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        x_reg      <= stax;
        y_reg      <= stay;
        endx_reg   <= endx;
        endy_reg   <= endy;
        sx_neg_reg <= (endx < stax);
        sy_neg_reg <= (endy < stay);
        dx_reg     <= dx_load;
        dy_reg     <= dy_load;
        err_reg    <= dx_load + dy_load;
      end else if (accept) begin
        x_reg   <= x_next;
        y_reg   <= y_next;
        err_reg <= err_next;
      end
    end
  end

  assign x = x_reg;
  assign y = y_reg;

endmodule

// File: tb/tb_line_raster.sv
// Self-checking bench for line_raster: directed lines, mid-line reset and
// randomized lines/back-pressure against a pixel-list reference model.
module tb_line_raster;

  localparam int W    = 10;
  localparam int XMAX = 639;
  localparam int YMAX = 479;

  logic         pclk = 1'b0;
  logic         rst;
  logic         go;
  logic         ready;
  logic [W-1:0] stax, stay, endx, endy;
  logic         busy, done, wr;
  logic [W-1:0] x, y;

  int checks = 0;
  int errors = 0;
  int exp_x[$];
  int exp_y[$];

  line_raster #(.COORD_W(W), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .pclk  (pclk),
    .rst   (rst),
    .stax  (stax),
    .stay  (stay),
    .endx  (endx),
    .endy  (endy),
    .go    (go),
    .busy  (busy),
    .done  (done),
    .ready (ready),
    .wr    (wr),
    .x     (x),
    .y     (y)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: ordered pixel list of the line, from the stepping rules.
  function automatic void build_line(input int x0, input int y0, input int x1, input int y1);
    int ddx, ddy, e, e2, cx, cy, sx, sy;
    exp_x.delete();
    exp_y.delete();
    ddx = (x1 >= x0) ? x1 - x0 : x0 - x1;
    ddy = (y1 >= y0) ? y0 - y1 : y1 - y0;
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    e   = ddx + ddy;
    cx  = x0;
    cy  = y0;
    forever begin
      exp_x.push_back(cx);
      exp_y.push_back(cy);
      if (cx == x1 && cy == y1) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; cx += sx; end
      if (e2 <= ddx) begin e += ddx; cy += sy; end
    end
  endfunction

  // Called at a negedge in IDLE or DONE; returns at the negedge showing done.
  task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                          input int rdy_pct, input int stall_idx, input int stall_len,
                          output int ncyc);
    int  idx, stalled, n, limit;
    bit  seen, r, exp_wr;
    build_line(x0, y0, x1, y1);
    n     = exp_x.size();
    limit = 20 * n + 50;
    stax = W'(x0); stay = W'(y0); endx = W'(x1); endy = W'(y1);
    go = 1'b1;
    @(negedge pclk);
    idx = 0; stalled = 0; seen = 0; ncyc = 0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (idx == n) begin
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_wr", wr, 0);
        seen = 1;
        ncyc = cyc;
        break;
      end
      exp_wr = 1'b1;
`ifdef LINE_RASTER_CLIP_EN
      if (exp_x[idx] > XMAX || exp_y[idx] > YMAX) exp_wr = 1'b0;
`endif
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_wr", wr, exp_wr);
      check("pix_x", x, exp_x[idx]);
      check("pix_y", y, exp_y[idx]);
      if (idx == stall_idx && stalled < stall_len) begin
        r = 1'b0;
        stalled++;
      end else begin
        r = ($urandom_range(99) < rdy_pct);
      end
      ready = r;
      // go and coordinates during RUN must be ignored
      go   = ($urandom_range(3) == 0);
      stax = W'($urandom); stay = W'($urandom);
      endx = W'($urandom); endy = W'($urandom);
      if (r || !exp_wr) idx++;
      @(negedge pclk);
    end
    go = 1'b0;
    if (!seen) check("line_timeout", idx, n + 1);
    $display("line (%0d,%0d)->(%0d,%0d): %0d pixels, %0d cycles, errors so far %0d",
             x0, y0, x1, y1, n, ncyc, errors);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wr"}, wr, 0);
  endtask

  initial begin
    int ncyc, x0, y0, x1, y1, span;
    rst = 1'b1; go = 1'b0; ready = 1'b0;
    stax = '0; stay = '0; endx = '0; endy = '0;
    repeat (2) @(negedge pclk);
    check_idle("reset");
    check("reset_x", x, 0);
    check("reset_y", y, 0);
    rst = 1'b0;
    @(negedge pclk);
    check_idle("idle");

    run_line(0, 0, 4, 0, 100, -1, 0, ncyc);
    check("horiz_cycles", ncyc, 5);
    @(negedge pclk);
    check_idle("after_horiz");

    run_line(3, 5, 1, 0, 100, -1, 0, ncyc);
    check("steep_cycles", ncyc, 6);
    // go in DONE: next line starts without an IDLE cycle
    run_line(0, 0, 4, 4, 100, 1, 3, ncyc);
    check("stall_cycles", ncyc, 8);
    run_line(7, 7, 7, 7, 100, -1, 0, ncyc);
    check("point_cycles", ncyc, 1);
    @(negedge pclk);
    check_idle("after_point");

    // Reset in the third RUN cycle of (0,0)->(9,0)
    stax = 0; stay = 0; endx = 9; endy = 0; ready = 1'b1;
    go = 1'b1;
    @(negedge pclk);
    go = 1'b0;
    repeat (2) @(negedge pclk);
    check("pre_rst_x", x, 2);
    rst = 1'b1;
    #1;
    check("midrst_wr", wr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_x", x, 0);
    @(negedge pclk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("post_rst_wr", wr, 0);
      check("post_rst_busy", busy, 0);
    end

    for (int i = 0; i < 40; i++) begin
      span = (i % 4 == 0) ? 1024 : 41;
      x0 = $urandom_range(span - 1); y0 = $urandom_range(span - 1);
      x1 = $urandom_range(span - 1); y1 = $urandom_range(span - 1);
      run_line(x0, y0, x1, y1, (span > 41) ? 70 : $urandom_range(100, 30), -1, 0, ncyc);
      if ($urandom_range(1) == 0) begin
        @(negedge pclk);
        check_idle("rand_idle");
      end
    end

`ifdef LINE_RASTER_CLIP_EN
    @(negedge pclk);
    run_line(636, 0, 642, 0, 100, -1, 0, ncyc);
    check("clip_cycles", ncyc, 7);
`endif

    @(negedge pclk);
    check_idle("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_raster.md
LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 SHALL have parameter COORD_W, default 10, coordinate width in bits (unsigned screen coordinates).
REQ-002 SHALL have parameter XMAX, default 639, last visible column (used only when clipping is compiled in).
REQ-003 SHALL have parameter YMAX, default 479, last visible row (used only when clipping is compiled in).
REQ-004 SHALL have port pclk  input  1  sole clock, all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports stax, stay, endx, endy  input  COORD_W each  line start and end points, sampled only on go acceptance.
REQ-007 SHALL have port go  input  1  start request.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-010 SHALL have port ready  input  1  downstream pixel sink can accept a pixel this cycle.
REQ-011 SHALL have port wr  output  1  pixel valid.
REQ-012 SHALL have ports x, y  output  COORD_W each  current pixel coordinate.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE: IDLE->RUN on go; RUN->DONE when the end pixel is accepted; DONE->RUN on go, else DONE->IDLE.
REQ-014 SHALL ignore go while in RUN.
REQ-015 SHALL, on go acceptance, register start/end points, set x=stax and y=stay, sx=+1 if endx>=stax else -1, sy=+1 if endy>=stay else -1, dx=|endx-stax|, dy=-|endy-stay|, err=dx+dy.
REQ-016 SHALL hold err, dx, dy as signed COORD_W+2 bits with no overflow across the full coordinate range, in all eight octants.
REQ-017 SHALL assert wr=1 with the current (x,y) every RUN cycle; a pixel is accepted when wr and ready are both 1.
REQ-018 SHALL step only on acceptance: e2=2*err; if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy; both updates apply in the same cycle when both conditions hold.
REQ-019 SHALL hold x, y, err and wr stable while wr=1 and ready=0.
REQ-020 SHALL emit exactly max(dx,-dy)+1 pixels per line, including both endpoints; stax=endx and stay=endy yields exactly one pixel.
REQ-021 SHALL pulse done for exactly the DONE cycle; busy=0 and wr=0 in IDLE and DONE.
REQ-022 SHALL accept go in DONE, entering RUN on the next cycle with no intervening IDLE cycle.

Reset
REQ-023 SHALL, on rst, immediately force state=IDLE, x=0, y=0, err=0, wr=0, busy=0, done=0, including mid-line; no pixel is emitted after reset asserts.
REQ-024 SHALL leave IDLE only on a go sampled after rst deasserts.

Configuration
REQ-025 SHALL, with LINE_RASTER_CLIP_EN defined, drive wr=0 for pixels with x>XMAX or y>YMAX and advance past such pixels in one cycle without waiting for ready.
REQ-026 SHALL, with LINE_RASTER_CLIP_EN undefined, emit every pixel and ignore XMAX/YMAX.
REQ-027 SHALL, in either mode, enter DONE one cycle after the end pixel is accepted or skipped.

Structure
REQ-028 SHALL place the FSM state enum and the default coordinate-width constant in shared package line_raster_pkg.
REQ-029 SHALL implement the err/x/y next-step arithmetic as one combinational sub-module, line_step.

Verification
REQ-030 SHALL cover (0,0)->(4,0) with ready=1: wr for 5 cycles at x=0..4, y=0, then done for 1 cycle.
REQ-031 SHALL cover (3,5)->(1,0): pixels (3,5),(3,4),(2,3),(2,2),(1,1),(1,0) in order.
REQ-032 SHALL cover ready=0 for 3 cycles after the second pixel of (0,0)->(4,4): x=y=1 held with wr=1, then (2,2),(3,3),(4,4).
REQ-033 SHALL cover (7,7)->(7,7): exactly one wr at (7,7), then done.
REQ-034 SHALL cover rst asserted in the third RUN cycle of (0,0)->(9,0): wr=0 and busy=0 immediately, and no wr until the next go.
REQ-035 SHALL cover, with LINE_RASTER_CLIP_EN and XMAX=639, the line (636,0)->(642,0): wr only at x=636..639, done after 7 cycles.
